// File: rtl/baud_gen_os.sv
// Oversampling baud generator: table or custom divisor, oversample / mid-bit / bit-end ticks,
// with synchronous phase realign for receiver start-bit detection.
module baud_gen_os #(
   parameter int unsigned CLK_FREQ   = 50_000_000,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned CNT_W      = 20
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             ena,
   input  logic             restart,
   input  logic [2:0]       baud_set,
   input  logic [CNT_W-1:0] div_custom,
   output logic             tick_os,
   output logic             tick_mid,
   output logic             tick_baud,
   output logic [CNT_W-1:0] div_active
);

   localparam int unsigned     PH_W       = $clog2(OVERSAMPLE);
   localparam logic [PH_W-1:0] PH_LAST    = PH_W'(OVERSAMPLE - 1);
   localparam logic [PH_W-1:0] PH_PRE_MID = PH_W'(OVERSAMPLE / 2 - 1);
   localparam logic [63:0]     MAX_DIV    = (64'd1 << CNT_W) - 64'd1;

   // Rounded clocks-per-oversample-tick for a given baud rate.
   function automatic logic [63:0] calc_div(input logic [63:0] rate);
      logic [63:0] den;
      den = rate * 64'(OVERSAMPLE);
      calc_div = (64'(CLK_FREQ) + den / 64'd2) / den;
   endfunction

   // Index 7 is the custom slot; its entry is never selected.
   localparam logic [63:0] DIV_TAB [8] = '{
      calc_div(64'd300),   calc_div(64'd1200),  calc_div(64'd2400),
      calc_div(64'd9600),  calc_div(64'd19200), calc_div(64'd38400),
      calc_div(64'd115200), 64'd2
   };
   localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_TAB[3]);

   for (genvar i = 0; i < 7; i++) begin : g_div_chk
      if (DIV_TAB[i] > MAX_DIV) begin : g_div_err
         $error("baud_gen_os: table divisor does not fit in CNT_W bits");
      end
   end

   if ((OVERSAMPLE < 4) || ((OVERSAMPLE % 2) != 0)) begin : g_os_err
      $error("baud_gen_os: OVERSAMPLE must be even and at least 4");
   end

   logic [CNT_W-1:0] os_cnt;
   logic [PH_W-1:0]  ph;
   logic [CNT_W-1:0] sel_div;
   logic             os_wrap;

   always_comb begin
      sel_div = CNT_W'(DIV_TAB[baud_set]);
      if (baud_set == 3'b111) begin
         sel_div = (div_custom < CNT_W'(2)) ? CNT_W'(2) : div_custom;
      end
      os_wrap = (os_cnt == (div_active - CNT_W'(1)));
   end

   // Divisor only reloads while idle, on realign, or at a bit boundary, never mid-bit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         os_cnt     <= '0;
         ph         <= '0;
         tick_os    <= 1'b0;
         tick_mid   <= 1'b0;
         tick_baud  <= 1'b0;
         div_active <= DIV_RST;
      end else if (!ena || restart) begin
         os_cnt     <= '0;
         ph         <= '0;
         tick_os    <= 1'b0;
         tick_mid   <= 1'b0;
         tick_baud  <= 1'b0;
         div_active <= sel_div;
      end else if (os_wrap) begin
         os_cnt   <= '0;
         tick_os  <= 1'b1;
         tick_mid <= (ph == PH_PRE_MID);
         if (ph == PH_LAST) begin
            ph         <= '0;
            tick_baud  <= 1'b1;
            div_active <= sel_div;
         end else begin
            ph         <= ph + PH_W'(1);
            tick_baud  <= 1'b0;
         end
      end else begin
         os_cnt    <= os_cnt + CNT_W'(1);
         tick_os   <= 1'b0;
         tick_mid  <= 1'b0;
         tick_baud <= 1'b0;
      end
   end

endmodule
